// File: rtl/fir_sequencer.sv
// rtl/fir_sequencer.sv - serial coefficient loader and periodic sample sequencer for an external FIR core.
module fir_sequencer #(
  parameter int BITS = 12,
  parameter int TAPS = 8,
  parameter int DIV  = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [BITS-1:0] cfg_data,
  input  logic            run_en,
  input  logic [BITS-1:0] sample_in,
  input  logic            clr_overrun,
  output logic            fir_start,
  output logic [BITS-1:0] fir_x,
  output logic            fir_lock,
  output logic            fir_coeff_load,
  output logic            fir_coeff,
  input  logic            fir_done,
  input  logic [BITS-1:0] fir_y,
  output logic            out_valid,
  output logic [BITS-1:0] out_data,
  output logic            loaded,
  output logic            overrun,
  output logic            busy
);

  localparam int WORDS = TAPS / 2;
  localparam int BW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam int WW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, WAIT} state_t;

  state_t          state, state_nx;
  logic [BITS-1:0] sreg;
  logic [BW-1:0]   bit_cnt;
  logic [WW-1:0]   word_cnt;
  logic [TW-1:0]   tick_cnt;
  logic            timing;
  logic            tick;
  logic            bit_last;
  logic            word_last;

  assign timing    = (state == RUN) || (state == WAIT);
  assign tick      = timing && (tick_cnt == TW'(DIV - 1));
  assign bit_last  = (bit_cnt == BW'(BITS - 1));
  assign word_last = (word_cnt == WW'(WORDS - 1));
  assign busy      = (state != IDLE);
  assign fir_coeff = fir_coeff_load & sreg[BITS-1];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx       = state;
    cfg_ready      = 1'b0;
    fir_coeff_load = 1'b0;
    fir_lock       = 1'b0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        fir_lock  = 1'b1;
        if (cfg_valid)             state_nx = LOAD;
        else if (run_en && loaded) state_nx = RUN;
      end
      LOAD: begin
        fir_coeff_load = 1'b1;
        fir_lock       = 1'b1;
        if (bit_last) state_nx = IDLE;
      end
      RUN: begin
        if (tick)         state_nx = WAIT;
        else if (!run_en) state_nx = IDLE;
      end
      WAIT: begin
        if (fir_done) state_nx = run_en ? RUN : IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg      <= '0;
      bit_cnt   <= '0;
      word_cnt  <= '0;
      tick_cnt  <= '0;
      loaded    <= 1'b0;
      overrun   <= 1'b0;
      fir_start <= 1'b0;
      fir_x     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      fir_start <= 1'b0;
      out_valid <= 1'b0;

      // A tick while the core is still busy drops that sample; set beats clear.
      if (tick && (state == WAIT)) overrun <= 1'b1;
      else if (clr_overrun)        overrun <= 1'b0;

      if (timing) tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
      else        tick_cnt <= '0;

      case (state)
        IDLE: begin
          if (cfg_valid) begin
            sreg    <= cfg_data;
            bit_cnt <= '0;
            if (word_cnt == '0) loaded <= 1'b0;
          end
        end
        LOAD: begin
          sreg    <= {sreg[BITS-2:0], 1'b0};
          bit_cnt <= bit_cnt + BW'(1);
          if (bit_last) begin
            bit_cnt <= '0;
            if (word_last) begin
              word_cnt <= '0;
              loaded   <= 1'b1;
            end else begin
              word_cnt <= word_cnt + WW'(1);
            end
          end
        end
        RUN: begin
          if (tick) begin
            fir_start <= 1'b1;
            fir_x     <= sample_in;
          end
        end
        WAIT: begin
          if (fir_done) begin
            out_data  <= fir_y;
            out_valid <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_sequencer.sv
// tb/tb_fir_sequencer.sv - directed bench for fir_sequencer at DIV=64 and DIV=16.
module tb_fir_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic [11:0] cfg_data;
  logic        run_en, run_en16;
  logic [11:0] sample_in;
  logic        clr_overrun, clr16;

  logic        cfg_ready, fir_start, fir_lock, fir_coeff_load, fir_coeff;
  logic [11:0] fir_x, out_data;
  logic        out_valid, loaded, overrun, busy;
  logic        fir_done;
  logic [11:0] fir_y;

  logic        cfg_ready16, fir_start16, fir_lock16, fir_coeff_load16, fir_coeff16;
  logic [11:0] fir_x16, out_data16;
  logic        out_valid16, loaded16, overrun16, busy16;
  logic        fir_done16;
  logic [11:0] fir_y16;

  logic        done_m = 1'b0, done16_m = 1'b0, force_done = 1'b0;
  int          lat = 0, lat16 = 0;
  int          n_assert = 0, n_fail = 0;

  assign fir_done   = done_m | force_done;
  assign fir_done16 = done16_m;

  always #5 clk = ~clk;

  fir_sequencer #(.BITS(12), .TAPS(8), .DIV(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_data(cfg_data), .run_en(run_en), .sample_in(sample_in),
    .clr_overrun(clr_overrun), .fir_start(fir_start), .fir_x(fir_x),
    .fir_lock(fir_lock), .fir_coeff_load(fir_coeff_load), .fir_coeff(fir_coeff),
    .fir_done(fir_done), .fir_y(fir_y), .out_valid(out_valid), .out_data(out_data),
    .loaded(loaded), .overrun(overrun), .busy(busy)
  );

  fir_sequencer #(.BITS(12), .TAPS(8), .DIV(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready16),
    .cfg_data(cfg_data), .run_en(run_en16), .sample_in(sample_in),
    .clr_overrun(clr16), .fir_start(fir_start16), .fir_x(fir_x16),
    .fir_lock(fir_lock16), .fir_coeff_load(fir_coeff_load16), .fir_coeff(fir_coeff16),
    .fir_done(fir_done16), .fir_y(fir_y16), .out_valid(out_valid16), .out_data(out_data16),
    .loaded(loaded16), .overrun(overrun16), .busy(busy16)
  );

  // FIR core stand-ins: result pulse 49 cycles after each start.
  always @(negedge clk) begin
    done_m = 1'b0;
    if (lat > 0) begin
      lat = lat - 1;
      if (lat == 0) done_m = 1'b1;
    end
    if (fir_start) lat = 49;
    done16_m = 1'b0;
    if (lat16 > 0) begin
      lat16 = lat16 - 1;
      if (lat16 == 0) done16_m = 1'b1;
    end
    if (fir_start16) lat16 = 49;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_word(input logic [11:0] w);
    cfg_valid = 1'b1;
    cfg_data  = w;
    step();
    cfg_valid = 1'b0;
    check("cfg_ready_in_load", cfg_ready, 0);
    for (int i = 0; i < 12; i++) begin
      check("coeff_load_high", fir_coeff_load, 1);
      check("coeff_bit", fir_coeff, w[11-i]);
      check("lock_in_load", fir_lock, 1);
      step();
    end
    check("coeff_load_low_after", fir_coeff_load, 0);
    check("coeff_zero_after", fir_coeff, 0);
    check("cfg_ready_after_word", cfg_ready, 1);
  endtask

  initial begin
    int  n;
    logic seen;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; run_en = 1'b0; run_en16 = 1'b0;
    sample_in = 12'h800; clr_overrun = 1'b0; clr16 = 1'b0;
    fir_y = 12'h123; fir_y16 = 12'h3C3;
    repeat (3) step();
    rst_n = 1'b1;
    step();

    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_loaded", loaded, 0);
    check("rst_overrun", overrun, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_fir_x", fir_x, 0);
    check("rst_fir_start", fir_start, 0);
    check("rst_coeff_load", fir_coeff_load, 0);
    check("rst_lock", fir_lock, 1);

    // Partial coefficient set must not allow running.
    load_word(12'h7FF);
    load_word(12'h400);
    check("loaded_after_2", loaded, 0);
    run_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 80; i++) begin
      step();
      if (fir_start || busy) seen = 1'b1;
    end
    check("partial_no_run", seen, 0);
    run_en = 1'b0;

    load_word(12'h200);
    check("loaded_after_3", loaded, 0);
    load_word(12'h100);
    check("loaded_after_4", loaded, 1);
    check("loaded16_after_4", loaded16, 1);

    // fir_done while idle is ignored.
    force_done = 1'b1;
    step();
    force_done = 1'b0;
    check("done_idle_no_valid", out_valid, 0);
    check("done_idle_busy", busy, 0);

    // First start exactly DIV cycles after entering RUN.
    run_en = 1'b1;
    step();
    check("run_busy", busy, 1);
    check("run_lock", fir_lock, 0);
    check("run_cfg_ready", cfg_ready, 0);
    repeat (63) step();
    check("start_not_early", fir_start, 0);
    step();
    check("start_at_64", fir_start, 1);
    check("fir_x_sample", fir_x, 12'h800);
    sample_in = 12'h0AB;
    step();
    check("start_one_cycle", fir_start, 0);
    check("fir_x_hold", fir_x, 12'h800);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin step(); n++; end
    check("out_valid_seen", out_valid, 1);
    check("out_data_123", out_data, 12'h123);
    check("no_overrun_div64", overrun, 0);
    step();
    check("out_valid_one_cycle", out_valid, 0);
    check("back_in_run", busy, 1);
    run_en = 1'b0;
    step();
    check("run_drop_idle", busy, 0);

    // Dropping run_en in WAIT still delivers the result.
    fir_y = 12'h2A5;
    run_en = 1'b1;
    n = 0;
    while (fir_start !== 1'b1 && n < 100) begin step(); n++; end
    check("second_start_seen", fir_start, 1);
    check("second_fir_x", fir_x, 12'h0AB);
    run_en = 1'b0;
    step();
    check("wait_not_aborted", busy, 1);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin step(); n++; end
    check("wait_drop_valid", out_valid, 1);
    check("wait_drop_data", out_data, 12'h2A5);
    check("wait_drop_idle", busy, 0);

    // DIV=16 with a 49-cycle core: ticks land in WAIT.
    run_en16 = 1'b1;
    n = 0;
    while (overrun16 !== 1'b1 && n < 80) begin step(); n++; end
    check("overrun_set", overrun16, 1);
    check("overrun_fir_x", fir_x16, 12'h0AB);
    clr16 = 1'b1;
    step();
    clr16 = 1'b0;
    check("overrun_cleared", overrun16, 0);
    clr16 = 1'b1;
    n = 0;
    while (overrun16 !== 1'b1 && n < 20) begin step(); n++; end
    check("overrun_set_beats_clr", overrun16, 1);
    clr16 = 1'b0;
    run_en16 = 1'b0;
    n = 0;
    while (out_valid16 !== 1'b1 && n < 80) begin step(); n++; end
    check("div16_valid", out_valid16, 1);
    check("div16_data", out_data16, 12'h3C3);
    check("div16_idle", busy16, 0);

    // Reset mid-load at bit 5 of word 0.
    cfg_valid = 1'b1;
    cfg_data  = 12'h555;
    step();
    cfg_valid = 1'b0;
    check("word0_clears_loaded", loaded, 0);
    repeat (5) step();
    check("mid_load_active", fir_coeff_load, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rst_mid_coeff_load", fir_coeff_load, 0);
    check("rst_mid_cfg_ready", cfg_ready, 1);
    check("rst_mid_loaded", loaded, 0);
    check("rst_mid_overrun16", overrun16, 0);
    check("rst_mid_out_data", out_data, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/fir_sequencer.md
FIR_SEQUENCER -- requirements
Module: fir_sequencer

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- BITS, 12, sample and coefficient width.
- TAPS, 8, FIR tap count (even); TAPS/2 coefficient words.
- DIV, 64, sample period in clk cycles.
- DIV SHALL be >= TAPS/2*BITS+4 for overrun-free operation.
REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- cfg_valid  in  1  coefficient word valid.
- cfg_ready  out  1  coefficient word accepted when high with cfg_valid.
- cfg_data  in  BITS  coefficient word, SFix<1,BITS-1>.
- run_en  in  1  enable periodic filtering.
- sample_in  in  BITS  unsigned input sample.
- clr_overrun  in  1  clears overrun.
- fir_start  out  1  FIR start pulse.
- fir_x  out  BITS  FIR sample input.
- fir_lock  out  1  FIR coefficient-rotation lock.
- fir_coeff_load  out  1  FIR serial-load enable.
- fir_coeff  out  1  FIR serial coefficient bit.
- fir_done  in  1  FIR result-valid pulse.
- fir_y  in  BITS  FIR result.
- out_valid  out  1  one-cycle result strobe.
- out_data  out  BITS  captured result.
- loaded  out  1  full coefficient set present.
- overrun  out  1  sticky, sample dropped.
- busy  out  1  state != IDLE.

Function
REQ-003 States: IDLE, LOAD, RUN, WAIT.
REQ-004 IDLE: cfg_ready=1; cfg_valid -> latch cfg_data into shift register, enter LOAD; else run_en && loaded -> RUN; else stay.
REQ-005 cfg_ready SHALL be 0 in LOAD, RUN and WAIT; cfg_valid has priority over run_en in IDLE.
REQ-006 Word order: host sends c[TAPS/2-1] first and c[0] last.
REQ-007 LOAD: fir_coeff_load=1 for exactly BITS consecutive cycles; fir_coeff = shift-register MSB (word sent MSB first); return to IDLE after the BITS-th cycle.
REQ-008 Word counter 0..TAPS/2-1 increments per completed word.
- Accepting word 0 clears loaded.
- Completing word TAPS/2-1 sets loaded and wraps the counter to 0.
REQ-009 fir_coeff_load SHALL be 0 outside LOAD; fir_coeff SHALL be 0 when fir_coeff_load=0.
REQ-010 fir_lock SHALL be 0 in RUN and WAIT, 1 in IDLE and LOAD.
REQ-011 Tick counter: reset to 0 in IDLE/LOAD; counts 0..DIV-1 in RUN/WAIT; tick when count==DIV-1, then wraps to 0.
- First tick occurs DIV cycles after entering RUN.
REQ-012 RUN, tick: fir_start=1 for one cycle, fir_x = sample_in sampled that cycle; enter WAIT. fir_x SHALL hold until next start.
REQ-013 RUN, run_en=0 without tick: enter IDLE.
REQ-014 WAIT, fir_done=1: out_data <= fir_y; out_valid=1 the next cycle, for exactly one cycle; then RUN if run_en else IDLE.
REQ-015 Tick in WAIT, including the same cycle as fir_done: no start; overrun set; sample dropped.
REQ-016 run_en deassert in WAIT SHALL NOT abort; the result is still delivered.
REQ-017 overrun: set has priority over clr_overrun in the same cycle.
REQ-018 fir_done outside WAIT SHALL be ignored.

Reset
REQ-019 rst_n=0 at any clk edge, including mid-LOAD or mid-WAIT, SHALL:
- force IDLE and clear the word, bit and tick counters.
- clear loaded and overrun.
- drive out_data=0, fir_x=0, and all strobes=0.
- drive cfg_ready=1 on the first cycle after release.

Verification
REQ-020 Load 4 words 0x7FF,0x400,0x200,0x100 -> fir_coeff_load high 12 cycles per word; first serial bits 0,1,1,1; loaded=1 after 48 load cycles.
REQ-021 loaded=1, run_en=1, sample_in=0x800, DIV=64 -> fir_start at cycle 64 with fir_x=0x800; model fir_done at +49 with fir_y=0x123 -> out_valid one cycle with out_data=0x123; overrun=0.
REQ-022 DIV=16, model done latency 49 -> ticks in WAIT set overrun; clr_overrun clears it; simultaneous set wins.
REQ-023 run_en=1 with only 2 of 4 words loaded -> remains IDLE, no fir_start.
REQ-024 run_en dropped during WAIT -> result delivered, then IDLE, busy=0.
REQ-025 rst_n pulsed mid-LOAD at bit 5 -> loaded=0, fir_coeff_load=0 next cycle, cfg_ready=1.
